// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM weight-loading path: loader FSM states
// and the default byte-per-word ratio.
package lstm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    SNAP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_RAM_WIDTH = 16;
  localparam int DEF_IN_WIDTH  = 8;
  localparam int BEATS         = DEF_RAM_WIDTH / DEF_IN_WIDTH;

  // Beats per RAM word for an arbitrary width pairing.
  function automatic int calc_beats(input int ram_width, input int in_width);
    return ram_width / in_width;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a stream of input bytes little-endian into RAM-wide words,
// flagging the cycle on which the final beat of a word arrives.
module byte_packer
  import lstm_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int IN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 word_valid,
  output logic [RAM_WIDTH-1:0] word
);

  localparam int NB = calc_beats(RAM_WIDTH, IN_WIDTH);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  logic [BW-1:0]        beat_q;
  logic [RAM_WIDTH-1:0] pack_q;
  logic [RAM_WIDTH-1:0] shifted;

  // New bytes enter at the top and move down, so after NB beats the
  // first byte of the word sits in the LSBs.
  generate
    if (NB > 1) begin : g_multi
      assign shifted = {in_data, pack_q[RAM_WIDTH-1:IN_WIDTH]};
    end else begin : g_single
      assign shifted = in_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q <= '0;
      pack_q <= '0;
    end else if (clear) begin
      beat_q <= '0;
      pack_q <= '0;
    end else if (in_valid) begin
      pack_q <= shifted;
      beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
    end
  end

  assign word_valid = in_valid && (beat_q == LAST_BEAT);
  assign word       = shifted;

endmodule

// File: rtl/weight_loader.sv
// Streams bytes into the weight RAM word by word, then pulses the RAM
// snapshot enable and reports completion.
module weight_loader
  import lstm_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 400,
  parameter int RAM_ADDR  = 9,
  parameter int IN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 we1,
  output logic                 ce1,
  output logic [RAM_ADDR-1:0]  addr1,
  output logic [RAM_WIDTH-1:0] win,
  output logic                 ce0,
  output logic                 busy,
  output logic                 done,
  output logic [RAM_ADDR-1:0]  word_cnt
);

  localparam logic [RAM_ADDR-1:0] LAST_ADDR = RAM_ADDR'(RAM_DEPTH - 1);
  // Saturation point; clipped to all-ones when RAM_DEPTH fills the address space.
  localparam logic [RAM_ADDR-1:0] CNT_MAX =
    (RAM_DEPTH < (1 << RAM_ADDR)) ? RAM_ADDR'(RAM_DEPTH) : RAM_ADDR'((1 << RAM_ADDR) - 1);

  state_t               state_q, state_d;
  logic                 accept;
  logic                 load_clear;
  logic                 word_valid;
  logic [RAM_WIDTH-1:0] word;

  assign s_ready    = (state_q == LOAD);
  assign accept     = s_valid && s_ready;
  assign load_clear = (state_q == IDLE) && start;

  byte_packer #(
    .RAM_WIDTH(RAM_WIDTH),
    .IN_WIDTH (IN_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (load_clear),
    .in_valid  (accept),
    .in_data   (s_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (word_valid && (word_cnt == LAST_ADDR)) state_d = FLUSH;
      FLUSH:   state_d = SNAP;
      SNAP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are derived from the next state so they line up with the state
  // they belong to; addr1/win only move on a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we1      <= 1'b0;
      ce1      <= 1'b0;
      addr1    <= '0;
      win      <= '0;
      ce0      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
    end else begin
      we1  <= 1'b0;
      ce1  <= 1'b0;
      ce0  <= (state_d == SNAP);
      done <= (state_d == DONE);
      busy <= (state_d == LOAD) || (state_d == FLUSH) || (state_d == SNAP);
      if (load_clear) begin
        word_cnt <= '0;
      end else if (word_valid) begin
        we1   <= 1'b1;
        ce1   <= 1'b1;
        addr1 <= word_cnt;
        win   <= word;
        if (word_cnt != CNT_MAX) word_cnt <= word_cnt + RAM_ADDR'(1);
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: a 4-word instance for directed vectors and
// corner sequences, and a default-size instance for a full random load.
module tb_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start_s, s_valid_s;
  logic [7:0]  s_data_s;
  logic        s_ready_s, we1_s, ce1_s, ce0_s, busy_s, done_s;
  logic [2:0]  addr1_s, word_cnt_s;
  logic [15:0] win_s;

  logic        start_l, s_valid_l;
  logic [7:0]  s_data_l;
  logic        s_ready_l, we1_l, ce1_l, ce0_l, busy_l, done_l;
  logic [8:0]  addr1_l, word_cnt_l;
  logic [15:0] win_l;

  weight_loader #(.RAM_WIDTH(16), .RAM_DEPTH(4), .RAM_ADDR(3), .IN_WIDTH(8)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .s_data(s_data_s), .s_valid(s_valid_s),
    .s_ready(s_ready_s), .we1(we1_s), .ce1(ce1_s), .addr1(addr1_s), .win(win_s),
    .ce0(ce0_s), .busy(busy_s), .done(done_s), .word_cnt(word_cnt_s)
  );

  weight_loader #(.RAM_WIDTH(16), .RAM_DEPTH(400), .RAM_ADDR(9), .IN_WIDTH(8)) dut_large (
    .clk(clk), .rst_n(rst_n), .start(start_l), .s_data(s_data_l), .s_valid(s_valid_l),
    .s_ready(s_ready_l), .we1(we1_l), .ce1(ce1_l), .addr1(addr1_l), .win(win_l),
    .ce0(ce0_l), .busy(busy_l), .done(done_l), .word_cnt(word_cnt_l)
  );

  typedef struct packed {
    logic        s_ready;
    logic        we1;
    logic        ce1;
    logic [2:0]  addr1;
    logic [15:0] win;
    logic        ce0;
    logic        busy;
    logic        done;
    logic [2:0]  word_cnt;
  } out_t;

  typedef struct packed {
    logic       start;
    logic       valid;
    logic [7:0] data;
    out_t       exp;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] ld[8];
  logic [7:0] big[800];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive observers: record transfers, writes and pulses with cycle stamps.
  int          xfer_s[$];
  int          wr_cyc_s[$];
  logic [2:0]  wr_addr_s[$];
  logic [15:0] wr_data_s[$];
  int          ce0_cyc_s[$];
  int          done_cyc_s[$];
  int          strobe_bad_s = 0;

  always @(negedge clk) begin
    if (s_valid_s && s_ready_s) xfer_s.push_back(cyc);
    if (we1_s) begin
      wr_cyc_s.push_back(cyc);
      wr_addr_s.push_back(addr1_s);
      wr_data_s.push_back(win_s);
    end
    if (we1_s !== ce1_s) strobe_bad_s++;
    if (ce0_s) ce0_cyc_s.push_back(cyc);
    if (done_s) done_cyc_s.push_back(cyc);
  end

  int          xfer_l[$];
  logic [8:0]  wr_addr_l[$];
  logic [15:0] wr_data_l[$];
  logic [15:0] ram_l[512];
  logic [15:0] snap_l[400];
  logic [8:0]  snap_cnt_l;
  int          ce0_cyc_l[$];
  int          done_cyc_l[$];
  int          strobe_bad_l = 0;

  always @(negedge clk) begin
    if (s_valid_l && s_ready_l) xfer_l.push_back(cyc);
    if (we1_l) begin
      ram_l[addr1_l] = win_l;
      wr_addr_l.push_back(addr1_l);
      wr_data_l.push_back(win_l);
    end
    if (we1_l !== ce1_l) strobe_bad_l++;
    if (ce0_l) ce0_cyc_l.push_back(cyc);
    if (done_l) begin
      done_cyc_l.push_back(cyc);
      for (int i = 0; i < 400; i++) snap_l[i] = ram_l[i];
      snap_cnt_l = word_cnt_l;
    end
  end

  function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                              input logic rdy, input logic we, input logic [2:0] a,
                              input logic [15:0] w, input logic c0, input logic b,
                              input logic dn, input logic [2:0] cnt);
    vec_t r;
    r.start = st;  r.valid = v;  r.data = d;
    r.exp.s_ready = rdy;  r.exp.we1 = we;  r.exp.ce1 = we;
    r.exp.addr1 = a;  r.exp.win = w;  r.exp.ce0 = c0;
    r.exp.busy = b;  r.exp.done = dn;  r.exp.word_cnt = cnt;
    return r;
  endfunction

  function automatic out_t sample_small();
    out_t o;
    o.s_ready = s_ready_s;  o.we1 = we1_s;  o.ce1 = ce1_s;
    o.addr1 = addr1_s;  o.win = win_s;  o.ce0 = ce0_s;
    o.busy = busy_s;  o.done = done_s;  o.word_cnt = word_cnt_s;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    start_s   = st;
    s_valid_s = v;
    s_data_s  = d;
  endtask

  task automatic drive_large(input logic st, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    start_l   = st;
    s_valid_l = v;
    s_data_l  = d;
  endtask

  // Full 4-word load from ld[], with optional idle gap and a stray start mid-load.
  task automatic run_small_load(input string tag, input int gap_before, input int gap_len,
                                input bit start_mid);
    int bw, bx, bc, bd, nw, nx;
    bit seen;
    bw = wr_cyc_s.size();  bx = xfer_s.size();
    bc = ce0_cyc_s.size(); bd = done_cyc_s.size();
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_before)
        for (int g = 0; g < gap_len; g++) applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(start_mid && (i == 2), 1'b1, ld[i]);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done_cyc_s.size() > bd) seen = 1'b1;
    end
    checkOutput({tag, " done_seen"}, 64'(seen), 64'd1);
    nw = wr_cyc_s.size() - bw;
    nx = xfer_s.size() - bx;
    checkOutput({tag, " write_count"}, 64'(nw), 64'd4);
    checkOutput({tag, " byte_count"}, 64'(nx), 64'd8);
    if (nw == 4 && nx == 8) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("%s addr%0d", tag, k), 64'(wr_addr_s[bw+k]), 64'(k));
        checkOutput($sformatf("%s data%0d", tag, k), 64'(wr_data_s[bw+k]),
                    64'({ld[2*k+1], ld[2*k]}));
        checkOutput($sformatf("%s wr_cycle%0d", tag, k), 64'(wr_cyc_s[bw+k]),
                    64'(xfer_s[bx+2*k+1] + 1));
      end
    end
    checkOutput({tag, " ce0_count"}, 64'(ce0_cyc_s.size() - bc), 64'd1);
    checkOutput({tag, " done_count"}, 64'(done_cyc_s.size() - bd), 64'd1);
    if (ce0_cyc_s.size() - bc == 1 && done_cyc_s.size() - bd == 1 && nx == 8) begin
      checkOutput({tag, " ce0_latency"}, 64'(ce0_cyc_s[bc] - xfer_s[bx+7]), 64'd2);
      checkOutput({tag, " done_latency"}, 64'(done_cyc_s[bd] - xfer_s[bx+7]), 64'd3);
    end
    checkOutput({tag, " word_cnt"}, 64'(word_cnt_s), 64'd4);
    checkOutput({tag, " busy_after"}, 64'(busy_s), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bw, bc, bd, mism, nw;
    bit seen;
    rst_n = 1'b0;
    start_s = 1'b0; s_valid_s = 1'b0; s_data_s = 8'h00;
    start_l = 1'b0; s_valid_l = 1'b0; s_data_l = 8'h00;
    for (int i = 0; i < 512; i++) ram_l[i] = 16'h0000;

    vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[1]  = mk(1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[2]  = mk(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'd0);
    vecs[3]  = mk(1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 3'd0, 16'h0201, 1'b0, 1'b1, 1'b0, 3'd1);
    vecs[4]  = mk(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 3'd0, 16'h0201, 1'b0, 1'b1, 1'b0, 3'd1);
    vecs[5]  = mk(1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 3'd1, 16'h0403, 1'b0, 1'b1, 1'b0, 3'd2);
    vecs[6]  = mk(1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 3'd1, 16'h0403, 1'b0, 1'b1, 1'b0, 3'd2);
    vecs[7]  = mk(1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 3'd2, 16'h0605, 1'b0, 1'b1, 1'b0, 3'd3);
    vecs[8]  = mk(1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 3'd2, 16'h0605, 1'b0, 1'b1, 1'b0, 3'd3);
    vecs[9]  = mk(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 3'd3, 16'h0807, 1'b0, 1'b1, 1'b0, 3'd4);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 16'h0807, 1'b1, 1'b1, 1'b0, 3'd4);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 16'h0807, 1'b0, 1'b0, 1'b1, 3'd4);
    vecs[12] = mk(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 3'd3, 16'h0807, 1'b0, 1'b0, 1'b0, 3'd4);
    vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 16'h0807, 1'b0, 1'b0, 1'b0, 3'd4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_small", 64'(sample_small()), 64'd0);
    checkOutput("reset_large", 64'({s_ready_l, we1_l, ce1_l, addr1_l, win_l, ce0_l, busy_l,
                                    done_l, word_cnt_l}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].data);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), 64'(sample_small()), 64'(vecs[i].exp));
    end

    $display("[TB] gap between bytes 03 and 04");
    for (int i = 0; i < 8; i++) ld[i] = 8'(i + 1);
    run_small_load("gap", 3, 5, 1'b0);

    $display("[TB] idle s_valid and stray start");
    bw = wr_cyc_s.size();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'hEE);
      @(negedge clk);
      checkOutput($sformatf("idle_s_ready%0d", i), 64'(s_ready_s), 64'd0);
    end
    checkOutput("idle_no_write", 64'(wr_cyc_s.size() - bw), 64'd0);
    for (int i = 0; i < 8; i++) ld[i] = 8'(8'h21 + i);
    run_small_load("stray_start", 99, 0, 1'b1);

    $display("[TB] reset mid-load");
    bw = wr_cyc_s.size(); bc = ce0_cyc_s.size(); bd = done_cyc_s.size();
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h31 + i));
    applyStimulus(1'b0, 1'b0, 8'h00);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_outputs", 64'(sample_small()), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    nw = wr_cyc_s.size() - bw;
    checkOutput("abort_write_count", 64'(nw), 64'd2);
    if (nw == 2) begin
      checkOutput("abort_word0", 64'({wr_addr_s[bw], wr_data_s[bw]}), 64'({3'd0, 16'h3231}));
      checkOutput("abort_word1", 64'({wr_addr_s[bw+1], wr_data_s[bw+1]}), 64'({3'd1, 16'h3433}));
    end
    checkOutput("abort_no_ce0", 64'(ce0_cyc_s.size() - bc), 64'd0);
    checkOutput("abort_no_done", 64'(done_cyc_s.size() - bd), 64'd0);
    for (int i = 0; i < 8; i++) ld[i] = 8'(8'h41 + i);
    run_small_load("after_reset", 99, 0, 1'b0);
    checkOutput("small_we_ce_pair", 64'(strobe_bad_s), 64'd0);

    $display("[TB] full-size random load");
    for (int i = 0; i < 800; i++) big[i] = 8'($urandom_range(0, 255));
    drive_large(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 800; i++) drive_large(1'b0, 1'b1, big[i]);
    drive_large(1'b0, 1'b0, 8'h00);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done_cyc_l.size() > 0) seen = 1'b1;
    end
    checkOutput("large done_seen", 64'(seen), 64'd1);
    checkOutput("large write_count", 64'(wr_addr_l.size()), 64'd400);
    checkOutput("large byte_count", 64'(xfer_l.size()), 64'd800);
    mism = 0;
    if (wr_addr_l.size() == 400)
      for (int k = 0; k < 400; k++)
        if (wr_addr_l[k] !== 9'(k) || wr_data_l[k] !== {big[2*k+1], big[2*k]}) mism++;
    checkOutput("large write_order_mismatches", 64'(mism), 64'd0);
    checkOutput("large ce0_count", 64'(ce0_cyc_l.size()), 64'd1);
    checkOutput("large done_count", 64'(done_cyc_l.size()), 64'd1);
    if (ce0_cyc_l.size() == 1 && done_cyc_l.size() == 1 && xfer_l.size() == 800) begin
      checkOutput("large ce0_latency", 64'(ce0_cyc_l[0] - xfer_l[799]), 64'd2);
      checkOutput("large done_latency", 64'(done_cyc_l[0] - xfer_l[799]), 64'd3);
    end
    mism = 0;
    for (int k = 0; k < 400; k++)
      if (snap_l[k] !== {big[2*k+1], big[2*k]}) mism++;
    checkOutput("large snapshot_mismatches", 64'(mism), 64'd0);
    checkOutput("large word_cnt_at_done", 64'(snap_cnt_l), 64'd400);
    checkOutput("large we_ce_pair", 64'(strobe_bad_l), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
